// File: rtl/sl_stream_merge_pkg.sv
// Shared constants and width helpers for the stream merge block.
// Provides clog2, default word/counter widths and the channel-id width.
package sl_stream_merge_pkg;

   localparam int DEF_WIDTH = 193;
   localparam int DEF_CNT_W = 16;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   // A single channel still needs a one-bit id port.
   function automatic int id_w(input int nch);
      return (nch > 1) ? clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/sl_stream_merge_if.sv
// Bundle of the merge block's stream, status and counter signals.
// master: producer/consumer side; slave: the merge block itself.
interface sl_stream_merge_if
   import sl_stream_merge_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
);
   localparam int IDW = id_w(NCH);

   logic [NCH*WIDTH-1:0] data_in;
   logic                 out_ready;
   logic [WIDTH-1:0]     data_out;
   logic [IDW-1:0]       ch_id_out;
   logic [NCH-1:0]       prog_full;
   logic [NCH-1:0]       overflow;
   logic [NCH*CNT_W-1:0] drop_cnt;

   modport master (
      output data_in, out_ready,
      input  data_out, ch_id_out, prog_full, overflow, drop_cnt
   );

   modport slave (
      input  data_in, out_ready,
      output data_out, ch_id_out, prog_full, overflow, drop_cnt
   );

endinterface

// File: rtl/sl_chan_fifo.sv
// Single-clock first-word-fall-through FIFO, async active-low reset.
// Ports: din/wr_en write side, dout/rd_en read side, empty/full/count status.
module sl_chan_fifo
   import sl_stream_merge_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         din,
   input  logic                     wr_en,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [clog2(DEPTH):0]    count
);
   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [AW:0]      cnt;
   logic             do_wr;
   logic             do_rd;

   assign empty = (cnt == '0);
   assign full  = (cnt == (AW+1)'(DEPTH));
   assign count = cnt;
   assign dout  = mem[rp];

   // A write into a full FIFO still fits when a word leaves the same cycle.
   assign do_wr = wr_en && (!full || rd_en);
   assign do_rd = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wp] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_wr) wp <= wp + 1'b1;
         if (do_rd) rp <= rp + 1'b1;
         unique case ({do_wr, do_rd})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/sl_stream_merge.sv
// Buffers NCH valid-tagged input streams and merges them round-robin.
// Ports: clk, rst_n, bus (data_in/out_ready in; data_out, ch_id_out, status out).
module sl_stream_merge
   import sl_stream_merge_pkg::*;
#(
   parameter int NCH       = 4,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = 16,
   parameter int PFULL_THR = 12,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   sl_stream_merge_if.slave bus
);
   localparam int IDW = id_w(NCH);
   localparam int IW1 = IDW + 1;
   localparam int CW  = clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] in_q   [NCH];
   logic [WIDTH-1:0] f_dout [NCH];
   logic [CW-1:0]    f_count[NCH];
   logic [CNT_W-1:0] cnt_q  [NCH];
   logic [NCH-1:0]   f_empty;
   logic [NCH-1:0]   f_full;
   logic [NCH-1:0]   wr;
   logic [NCH-1:0]   pop;
   logic [NCH-1:0]   drop;
   logic [NCH-1:0]   ovf_q;
   logic [WIDTH-1:0] out_q;
   logic [IDW-1:0]   id_q;
   logic [IDW-1:0]   rr_q;
   logic [IW1-1:0]   idx;
   logic [IDW-1:0]   cand;
   logic [IDW-1:0]   gnt;
   logic             gnt_vld;
   logic             load;
   logic             clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) in_q[c] <= '0;
      end else begin
         for (int c = 0; c < NCH; c++)
            in_q[c] <= bus.data_in[c*WIDTH +: WIDTH];
      end
   end

   // First non-empty channel at or after the rotating pointer.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = '0;
      idx     = '0;
      cand    = '0;
      for (int i = 0; i < NCH; i++) begin
         idx = IW1'(rr_q) + IW1'(i);
         if (idx >= IW1'(NCH)) idx = idx - IW1'(NCH);
         cand = idx[IDW-1:0];
         if (!gnt_vld && !f_empty[cand]) begin
            gnt_vld = 1'b1;
            gnt     = cand;
         end
      end
   end

   assign load  = (!out_q[WIDTH-1] || bus.out_ready) && gnt_vld;
   assign clear = out_q[WIDTH-1] && bus.out_ready && !gnt_vld;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign pop[c]  = load && (gnt == IDW'(c));
      assign drop[c] = in_q[c][WIDTH-1] && f_full[c] && !pop[c];
      assign wr[c]   = in_q[c][WIDTH-1] && !drop[c];

      sl_chan_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .din   (in_q[c]),
         .wr_en (wr[c]),
         .rd_en (pop[c]),
         .dout  (f_dout[c]),
         .empty (f_empty[c]),
         .full  (f_full[c]),
         .count (f_count[c])
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q[c] <= '0;
            ovf_q[c] <= 1'b0;
         end else if (drop[c]) begin
            ovf_q[c] <= 1'b1;
            if (cnt_q[c] != CNT_MAX) cnt_q[c] <= cnt_q[c] + 1'b1;
         end
      end

      assign bus.prog_full[c] = f_count[c] >= CW'(PFULL_THR);
      assign bus.drop_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
         id_q  <= '0;
         rr_q  <= '0;
      end else if (load) begin
         out_q <= f_dout[gnt];
         id_q  <= gnt;
         rr_q  <= (gnt == IDW'(NCH-1)) ? '0 : gnt + 1'b1;
      end else if (clear) begin
         out_q <= '0;
         id_q  <= '0;
      end
   end

   assign bus.data_out  = out_q;
   assign bus.ch_id_out = id_q;
   assign bus.overflow  = ovf_q;

endmodule
